hpdcache_sram_wmask_1rw_ctrl: RTL and testbench
===============================================

// Module: hpdcache_sram_wmask_1rw_ctrl
// PURPOSE
//  Shares one hpdcache_sram_wmask_1rw macro between a read requester and a masked-write
//  requester. Sits between cache pipeline/refill logic and the SRAM.
//  Arbitrates the single RW port with bounded write starvation and returns read data one
//  cycle after grant. Optionally sweeps the array to zero after reset.
// PARAMETERS
//  ADDR_SIZE      6             SRAM address width
//  DATA_SIZE      32            bits per data word
//  NDATA          1             words per SRAM row
//  DEPTH          2**ADDR_SIZE  rows swept by init; legal addresses 0..DEPTH-1
//  WR_STARVE_MAX  4             max consecutive cycles a valid write may lose (>=1)
// PORTS
//  clk            in   1                  clock; all state on rising edge
//  rst_n          in   1                  asynchronous reset, active low
//  rd_req_valid   in   1                  read request valid
//  rd_req_ready   out  1                  read request granted this cycle
//  rd_req_addr    in   ADDR_SIZE          read row address
//  rd_rsp_valid   out  1                  read data valid (no backpressure)
//  rd_rsp_rdata   out  NDATA*DATA_SIZE    read data
//  wr_req_valid   in   1                  write request valid
//  wr_req_ready   out  1                  write request granted this cycle
//  wr_req_addr    in   ADDR_SIZE          write row address
//  wr_req_wdata   in   NDATA*DATA_SIZE    write data
//  wr_req_wmask   in   NDATA*DATA_SIZE    per-bit write enable (1 = write bit)
//  init_done      out  1                  array ready for traffic
//  sram_cs/we     out  1 each             SRAM chip select / write enable
//  sram_addr      out  ADDR_SIZE          SRAM address
//  sram_wdata     out  NDATA*DATA_SIZE    SRAM write data
//  sram_wmask     out  NDATA*DATA_SIZE    SRAM write mask
//  sram_rdata     in   NDATA*DATA_SIZE    SRAM read data (holds until next read)
// BEHAVIOUR
//  - FSM: INIT -> RUN. Reset enters INIT (or RUN directly when init compiled out).
//  - Reset values: rd_rsp_valid=0, init_done=0, starve_cnt=0, init_addr=0; while in
//    reset all ready/sram_cs outputs are 0.
//  - RUN grant (combinational from valids): only rd valid -> read; only wr valid -> write;
//    both -> read unless starve_cnt==WR_STARVE_MAX, then write. Exactly one ready high.
//  - Grant drives sram_cs=1, sram_we=(write), sram_addr/wdata/wmask from granted requester;
//    otherwise sram_cs=0, sram_we=0, data/mask/addr=0.
//  - starve_cnt: +1 (saturating at WR_STARVE_MAX) when wr_req_valid && !wr_req_ready;
//    cleared on write grant or when wr_req_valid=0.
//  - Read latency 1: rd_rsp_valid registered = read grant; rd_rsp_rdata = sram_rdata.
//  - Same-cycle read and write to same addr: grant rule applies; losing request waits; no
//    forwarding. Write granted cycle N, read same addr at N+1 returns new data at N+2.
//  - Back-to-back reads allowed every cycle; writes every cycle.
//  - Async reset mid-operation: pending rd_rsp dropped, FSM restarts; requesters re-issue.
//  - Requesters must hold valid/addr/data stable until ready (not checked).
// CONFIGURATION
//  HPDCACHE_SRAM_CTRL_INIT_EN defined: INIT writes zero, full mask, one row per cycle from
//   addr 0 to DEPTH-1 (DEPTH cycles); rd/wr ready=0 during INIT; after last row -> RUN and
//   init_done=1 next cycle; init_addr wraps to 0 and is unused after.
//  Undefined: no sweep, FSM starts in RUN, init_done=1 first cycle after reset release,
//   array contents undefined until written.
// TESTING
//  - INIT_EN, DEPTH=64: release reset -> 64 cycles sram_we=1, addr 0..63, wmask all 1s,
//    then init_done=1; read addr 17 returns 0.
//  - Write addr 5 data 0xA5A5A5A5 mask 0xFFFF0000 over 0x11111111 -> read 5 gives
//    0xA5A51111, rd_rsp_valid exactly 1 cycle after rd_req_ready.
//  - rd and wr valid every cycle, WR_STARVE_MAX=4 -> pattern 4 reads, 1 write, repeating;
//    starve_cnt never exceeds 4.
//  - Write addr 9 cycle N, read addr 9 cycle N+1 -> new data at N+2; simultaneous rd/wr
//    addr 9 with starve_cnt=0 -> read wins, returns old data.
//  - Assert rst_n low mid-INIT (addr 30) and one cycle after a read grant -> rd_rsp_valid=0,
//    sweep restarts from addr 0.
//  - INIT_EN undefined -> init_done=1 first cycle after reset, first write granted at once.

Source files
------------

// File: rtl/hpdcache_sram_wmask_1rw_ctrl.sv
// hpdcache_sram_wmask_1rw_ctrl: arbitrates one 1RW masked-write SRAM between a reader and a writer.
// Define HPDCACHE_SRAM_CTRL_INIT_EN to zero the array row by row after reset.
module hpdcache_sram_wmask_1rw_ctrl #(
  parameter int ADDR_SIZE     = 6,
  parameter int DATA_SIZE     = 32,
  parameter int NDATA         = 1,
  parameter int DEPTH         = 2**ADDR_SIZE,
  parameter int WR_STARVE_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rd_req_valid,
  output logic                         rd_req_ready,
  input  logic [ADDR_SIZE-1:0]         rd_req_addr,
  output logic                         rd_rsp_valid,
  output logic [NDATA*DATA_SIZE-1:0]   rd_rsp_rdata,
  input  logic                         wr_req_valid,
  output logic                         wr_req_ready,
  input  logic [ADDR_SIZE-1:0]         wr_req_addr,
  input  logic [NDATA*DATA_SIZE-1:0]   wr_req_wdata,
  input  logic [NDATA*DATA_SIZE-1:0]   wr_req_wmask,
  output logic                         init_done,
  output logic                         sram_cs,
  output logic                         sram_we,
  output logic [ADDR_SIZE-1:0]         sram_addr,
  output logic [NDATA*DATA_SIZE-1:0]   sram_wdata,
  output logic [NDATA*DATA_SIZE-1:0]   sram_wmask,
  input  logic [NDATA*DATA_SIZE-1:0]   sram_rdata
);
  localparam int CW = $clog2(WR_STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(WR_STARVE_MAX);
  localparam logic [ADDR_SIZE-1:0] LAST_ROW = ADDR_SIZE'(DEPTH - 1);
  typedef enum logic {ST_INIT, ST_RUN} state_t;
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
  localparam state_t ST_RESET = ST_INIT;
`else
  localparam state_t ST_RESET = ST_RUN;
`endif
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_starve_cnt;
  logic [ADDR_SIZE-1:0] r_init_addr;
  logic r_rd_rsp_valid, r_init_done;
  logic w_init, w_run, w_init_last, w_wr_gnt, w_rd_gnt;
  // Gated by rst_n so the SRAM port is idle for the whole time reset is held.
  assign w_init      = rst_n && r_state == ST_INIT;
  assign w_run       = rst_n && r_state == ST_RUN;
  assign w_init_last = r_init_addr == LAST_ROW;
  assign w_wr_gnt    = w_run && wr_req_valid && (!rd_req_valid || r_starve_cnt == STARVE_MAX);
  assign w_rd_gnt    = w_run && rd_req_valid && !w_wr_gnt;
  assign rd_req_ready = w_rd_gnt;
  assign wr_req_ready = w_wr_gnt;
  assign rd_rsp_valid = r_rd_rsp_valid;
  assign rd_rsp_rdata = sram_rdata;
  assign init_done    = r_init_done;
  always_comb begin
    w_state_nxt = (r_state == ST_INIT && w_init_last) ? ST_RUN : r_state;
    sram_cs     = w_init || w_wr_gnt || w_rd_gnt;
    sram_we     = w_init || w_wr_gnt;
    sram_addr   = w_init ? r_init_addr : w_wr_gnt ? wr_req_addr : w_rd_gnt ? rd_req_addr : '0;
    sram_wdata  = w_wr_gnt ? wr_req_wdata : '0;
    sram_wmask  = w_init ? '1 : w_wr_gnt ? wr_req_wmask : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_RESET;
      r_starve_cnt   <= '0;
      r_init_addr    <= '0;
      r_rd_rsp_valid <= 1'b0;
      r_init_done    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_starve_cnt   <= (wr_req_valid && !w_wr_gnt) ?
                        ((r_starve_cnt == STARVE_MAX) ? r_starve_cnt : r_starve_cnt + CW'(1)) : '0;
      r_init_addr    <= (r_state == ST_INIT) ? (w_init_last ? '0 : r_init_addr + ADDR_SIZE'(1)) : r_init_addr;
      r_rd_rsp_valid <= w_rd_gnt;
      r_init_done    <= r_init_done || w_state_nxt == ST_RUN;
    end
  end
endmodule

// File: tb/tb_hpdcache_sram_wmask_1rw_ctrl.sv
// tb_hpdcache_sram_wmask_1rw_ctrl: directed bench with a behavioural masked-write SRAM.
module tb_hpdcache_sram_wmask_1rw_ctrl;
  localparam int AW = 6;
  localparam int W = 32;
  localparam int DEPTH = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd_req_valid, rd_req_ready, rd_rsp_valid;
  logic [AW-1:0] rd_req_addr;
  logic [W-1:0] rd_rsp_rdata;
  logic wr_req_valid, wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [W-1:0] wr_req_wdata, wr_req_wmask;
  logic init_done, sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [W-1:0] sram_wdata, sram_wmask, sram_rdata;
  logic [W-1:0] mem [DEPTH];
  int checks = 0;
  int failures = 0;

  hpdcache_sram_wmask_1rw_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(W), .NDATA(1), .DEPTH(DEPTH), .WR_STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_rdata(rd_rsp_rdata),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_wdata(wr_req_wdata), .wr_req_wmask(wr_req_wmask),
    .init_done(init_done), .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
      else sram_rdata <= mem[sram_addr];
    end
  end

  task automatic drive(input logic rv, input logic [AW-1:0] ra, input logic wv, input logic [AW-1:0] wa,
                       input logic [W-1:0] wd, input logic [W-1:0] wm);
    @(negedge clk);
    rd_req_valid = rv;
    rd_req_addr = ra;
    wr_req_valid = wv;
    wr_req_addr = wa;
    wr_req_wdata = wd;
    wr_req_wmask = wm;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, 6'd1, 1'b1, 6'd2, 32'h1, 32'hFFFF_FFFF);
    checks++; if (rd_req_ready !== 1'b0) begin failures++; $display("FAIL reset_rd_ready got=%b exp=0", rd_req_ready); end
    checks++; if (wr_req_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%b exp=0", wr_req_ready); end
    checks++; if (sram_cs !== 1'b0) begin failures++; $display("FAIL reset_sram_cs got=%b exp=0", sram_cs); end
    checks++; if (rd_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rd_rsp_valid); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
  endtask

`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
  task automatic test_init;
    @(negedge clk);
    rst_n = 1'b1;
    rd_req_valid = 1'b1;
    rd_req_addr = 6'd17;
    wr_req_valid = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if ({sram_cs, sram_we, rd_req_ready, init_done} !== 4'b1100 || sram_addr !== AW'(i) ||
          sram_wmask !== 32'hFFFF_FFFF || sram_wdata !== 32'h0) begin
        failures++;
        $display("FAIL init_row %0d got cs/we/rdy/done=%b%b%b%b addr=%0d mask=%h data=%h", i,
                 sram_cs, sram_we, rd_req_ready, init_done, sram_addr, sram_wmask, sram_wdata);
      end
    end
    drive(1'b0, 6'd0, 1'b0, 6'd0, 32'h0, 32'h0);
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL init_done_after_sweep got=%b exp=1", init_done); end
    drive(1'b1, 6'd17, 1'b0, 6'd0, 32'h0, 32'h0);
    checks++; if (rd_req_ready !== 1'b1) begin failures++; $display("FAIL init_read17_ready got=%b exp=1", rd_req_ready); end
    drive(1'b0, 6'd0, 1'b0, 6'd0, 32'h0, 32'h0);
    checks++; if (rd_rsp_valid !== 1'b1 || rd_rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL init_read17_data got v=%b d=%h exp v=1 d=00000000", rd_rsp_valid, rd_rsp_rdata); end
  endtask
`else
  task automatic test_no_init;
    @(negedge clk);
    rst_n = 1'b1;
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b1;
    wr_req_addr = 6'd3;
    wr_req_wdata = 32'h77;
    wr_req_wmask = 32'hFFFF_FFFF;
    #1;
    checks++; if (wr_req_ready !== 1'b1 || sram_we !== 1'b1) begin
      failures++; $display("FAIL first_write_grant got rdy=%b we=%b exp 1 1", wr_req_ready, sram_we); end
    drive(1'b0, 6'd0, 1'b0, 6'd0, 32'h0, 32'h0);
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL no_init_done got=%b exp=1", init_done); end
  endtask
`endif

  task automatic test_masked_write;
    drive(1'b0, 6'd0, 1'b1, 6'd5, 32'h1111_1111, 32'hFFFF_FFFF);
    checks++; if (wr_req_ready !== 1'b1 || sram_addr !== 6'd5 || sram_wmask !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL mw_first got rdy=%b addr=%0d mask=%h exp 1 5 ffffffff", wr_req_ready, sram_addr, sram_wmask); end
    drive(1'b0, 6'd0, 1'b1, 6'd5, 32'hA5A5_A5A5, 32'hFFFF_0000);
    checks++; if (sram_wdata !== 32'hA5A5_A5A5 || sram_wmask !== 32'hFFFF_0000 || sram_we !== 1'b1) begin
      failures++; $display("FAIL mw_second got d=%h m=%h we=%b", sram_wdata, sram_wmask, sram_we); end
    drive(1'b1, 6'd5, 1'b0, 6'd0, 32'h0, 32'h0);
    checks++; if (rd_req_ready !== 1'b1 || sram_cs !== 1'b1 || sram_we !== 1'b0 || rd_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL mw_read_grant got rdy=%b cs=%b we=%b rv=%b exp 1 1 0 0", rd_req_ready, sram_cs, sram_we, rd_rsp_valid); end
    drive(1'b0, 6'd0, 1'b0, 6'd0, 32'h0, 32'h0);
    checks++; if (rd_rsp_valid !== 1'b1 || rd_rsp_rdata !== 32'hA5A5_1111) begin
      failures++; $display("FAIL mw_read_data got v=%b d=%h exp v=1 d=a5a51111", rd_rsp_valid, rd_rsp_rdata); end
    drive(1'b0, 6'd0, 1'b0, 6'd0, 32'h0, 32'h0);
    checks++; if (rd_rsp_valid !== 1'b0) begin failures++; $display("FAIL mw_rsp_one_cycle got=%b exp=0", rd_rsp_valid); end
  endtask

  task automatic test_starve;
    logic exp_w;
    drive(1'b0, 6'd7, 1'b0, 6'd8, 32'hFFFF, 32'hFFFF);
    checks++; if (sram_cs !== 1'b0 || sram_we !== 1'b0 || sram_addr !== 6'd0 || sram_wdata !== 32'h0 || sram_wmask !== 32'h0) begin
      failures++; $display("FAIL idle_outputs got cs=%b we=%b a=%0d d=%h m=%h exp all 0", sram_cs, sram_we, sram_addr, sram_wdata, sram_wmask); end
    for (int c = 0; c < 15; c++) begin
      drive(1'b1, 6'd1, 1'b1, 6'd2, W'(c), 32'hFFFF_FFFF);
      exp_w = (c % 5) == 4;
      checks++; if (wr_req_ready !== exp_w || rd_req_ready !== !exp_w) begin
        failures++; $display("FAIL starve_cycle %0d got wr=%b rd=%b exp wr=%b rd=%b", c, wr_req_ready, rd_req_ready, exp_w, !exp_w); end
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b0, 6'd0, 1'b1, 6'd9, 32'h1234_5678, 32'hFFFF_FFFF);
    checks++; if (wr_req_ready !== 1'b1) begin failures++; $display("FAIL raw_w_old got=%b exp=1", wr_req_ready); end
    drive(1'b0, 6'd0, 1'b1, 6'd9, 32'hCAFE_F00D, 32'hFFFF_FFFF);
    checks++; if (wr_req_ready !== 1'b1) begin failures++; $display("FAIL raw_w_new got=%b exp=1", wr_req_ready); end
    drive(1'b1, 6'd9, 1'b0, 6'd0, 32'h0, 32'h0);
    checks++; if (rd_req_ready !== 1'b1) begin failures++; $display("FAIL raw_rd_grant got=%b exp=1", rd_req_ready); end
    drive(1'b1, 6'd9, 1'b1, 6'd9, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    checks++; if (rd_rsp_valid !== 1'b1 || rd_rsp_rdata !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL raw_new_data got v=%b d=%h exp v=1 d=cafef00d", rd_rsp_valid, rd_rsp_rdata); end
    checks++; if (rd_req_ready !== 1'b1 || wr_req_ready !== 1'b0) begin
      failures++; $display("FAIL same_addr_read_wins got rd=%b wr=%b exp 1 0", rd_req_ready, wr_req_ready); end
    drive(1'b0, 6'd0, 1'b1, 6'd9, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    checks++; if (rd_rsp_valid !== 1'b1 || rd_rsp_rdata !== 32'hCAFE_F00D || wr_req_ready !== 1'b1) begin
      failures++; $display("FAIL same_addr_old_data got v=%b d=%h wr=%b exp v=1 d=cafef00d wr=1", rd_rsp_valid, rd_rsp_rdata, wr_req_ready); end
    drive(1'b1, 6'd9, 1'b0, 6'd0, 32'h0, 32'h0);
    drive(1'b0, 6'd0, 1'b0, 6'd0, 32'h0, 32'h0);
    checks++; if (rd_rsp_valid !== 1'b1 || rd_rsp_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL late_write_data got v=%b d=%h exp v=1 d=deadbeef", rd_rsp_valid, rd_rsp_rdata); end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 6'd9, 1'b0, 6'd0, 32'h0, 32'h0);
    checks++; if (rd_req_ready !== 1'b1) begin failures++; $display("FAIL mid_rd_grant got=%b exp=1", rd_req_ready); end
    @(negedge clk);
    rd_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (rd_rsp_valid !== 1'b0 || sram_cs !== 1'b0 || init_done !== 1'b0) begin
      failures++; $display("FAIL mid_reset_drop got rv=%b cs=%b done=%b exp 0 0 0", rd_rsp_valid, sram_cs, init_done); end
    @(negedge clk);
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    checks++; if (sram_addr !== 6'd30 || sram_we !== 1'b1 || init_done !== 1'b0) begin
      failures++; $display("FAIL sweep_at_30 got addr=%0d we=%b done=%b exp 30 1 0", sram_addr, sram_we, init_done); end
    rst_n = 1'b0;
    #1;
    checks++; if (sram_cs !== 1'b0) begin failures++; $display("FAIL sweep_reset_cs got=%b exp=0", sram_cs); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (sram_addr !== 6'd0 || sram_we !== 1'b1 || sram_cs !== 1'b1) begin
      failures++; $display("FAIL sweep_restart got addr=%0d cs=%b we=%b exp 0 1 1", sram_addr, sram_cs, sram_we); end
    repeat (DEPTH) @(negedge clk);
    #1;
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL resweep_done got=%b exp=1", init_done); end
`else
    rst_n = 1'b1;
    wr_req_valid = 1'b1;
    wr_req_addr = 6'd9;
    #1;
    checks++; if (wr_req_ready !== 1'b1 || rd_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL post_reset_write got rdy=%b rv=%b exp 1 0", wr_req_ready, rd_rsp_valid); end
    drive(1'b0, 6'd0, 1'b0, 6'd0, 32'h0, 32'h0);
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL post_reset_done got=%b exp=1", init_done); end
`endif
  endtask

  initial begin
    rd_req_valid = 1'b0;
    rd_req_addr = '0;
    wr_req_valid = 1'b0;
    wr_req_addr = '0;
    wr_req_wdata = '0;
    wr_req_wmask = '0;
    test_reset();
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
    test_init();
`else
    test_no_init();
`endif
    test_masked_write();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
